lc3_obj_loader: RTL and testbench
=================================

# lc3_obj_loader

Program-image loader for the LC-3 memory's direct port. It accepts a byte stream, for example from a UART receiver, in LC-3 object format: big-endian 16-bit words, an origin word, a word-count word, then the payload. It writes each payload word through the `address_in_direct` / `data_in_direct` / write-enable side of the two-port RAM while the CPU side stays idle. It is the writer that fills memory before the datapath runs.

## Interface
Parameters:
- `ADDR_W`, 16: address width; the pointer wraps modulo 2^ADDR_W.
- `DATA_W`, 16: memory word width; must be 16 (two bytes per word).

Ports:
- `clk`  in  1  single clock; also drives the RAM's `clk_direct`.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored otherwise.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `address_out`  out  16  to the RAM's `address_in_direct`.
- `data_out`  out  16  to the RAM's `data_in_direct`.
- `wren_out`  out  1  direct-port write enable.
- `mem_q`  in  16  the RAM's `mem_out_direct` (read-back data).
- `busy`  out  1  a load is in progress.
- `done`  out  1  load completed; held until the next `start`.
- `error`  out  1  verify mismatch; held until the next `start`.
- `words_written`  out  16  payload words committed in this load.

## Operation
- A byte transfers when `in_valid && in_ready` at a rising `clk`.
- Bytes pair up high byte first: word = {first, second}.
- States:
  - IDLE → ORG on `start`.
  - ORG: collects 2 bytes into `org`, then → CNT.
  - CNT: collects 2 bytes into `remaining`. Count 0 → DONE; otherwise `ptr` = `org`, → DATA.
  - DATA: collects 2 bytes into `word`, then → WRITE.
  - WRITE: one cycle with `wren_out`=1, `address_out`=`ptr`, `data_out`=`word`. Goes → VRD if verify is compiled in, else → ADV.
  - VRD: `wren_out`=0, `address_out`=`ptr`, then → VCMP.
  - VCMP: `mem_q` ≠ `word` → ERROR; otherwise → ADV.
  - ADV: `ptr`++ (0xFFFF wraps to 0x0000), `remaining`--, `words_written`++. Then → DONE if `remaining` reaches 0, else → DATA.
  - DONE / ERROR: idle; `start` → ORG, clearing `done`, `error` and `words_written`.
- `in_ready`=1 only in ORG, CNT and DATA. It is 0 in every other state, including the cycle after the second byte of a word.
- `busy`=1 in every state except IDLE, DONE and ERROR.
- `start` while busy: ignored.
- `in_valid` outside a receiving state: ignored; bytes are not consumed.
- A stream stall (`in_valid`=0) holds the state indefinitely; there is no timeout.
- `wren_out` is asserted only in WRITE; it is never asserted in any other state.

## Timing
- Reset (async assert, `reset`=0): state IDLE, all outputs 0, internal registers 0.
- Reset mid-load: the load aborts immediately. Words already written stay in RAM; no cleanup writes occur.
- Release is synchronized to `clk`; the first state transition can occur on the second rising edge after release.
- Per-word minimum cycles, with `in_valid` held high:
  - Without verify: 2 accept + 1 WRITE + 1 ADV = 4.
  - With verify: 6.
- Read-back: the RAM registers the address, so `mem_q` is valid in the cycle after VRD, which is VCMP. VCMP samples `mem_q` combinationally.
- `done` / `error` rise on the edge that enters DONE / ERROR.
- `words_written` updates on the ADV edge.

## Configuration
- `LC3_LOADER_VERIFY_EN` defined: VRD and VCMP states exist, and every write is read back and compared.
- Undefined: WRITE goes directly to ADV. `error` is tied to 0 and `mem_q` is unused.

## Structure
- Package `lc3_loader_pkg` holds:
  - the state enum: IDLE, ORG, CNT, DATA, WRITE, VRD, VCMP, ADV, DONE, ERROR;
  - the localparams for header word count (2) and bytes per word (2).
- Sub-module `byte_pair_assembler` packs the bytes. It holds the phase bit and the high-byte register and emits a one-cycle `word_valid` pulse. Its phase bit clears on `start` and on reset.

## Test plan
- Basic load, verify off:
  - Stimulus: bytes 30 00 00 02 12 34 AB CD.
  - Required: writes 0x1234 @0x3000 and 0xABCD @0x3001; `done`=1; `words_written`=2; exactly 2 `wren_out` pulses.
- Zero count:
  - Stimulus: 40 00 00 00.
  - Required: `done`=1 with no `wren_out` pulse; `words_written`=0.
- Wrap-around:
  - Stimulus: origin 0xFFFF, count 2, words 0x1111 and 0x2222.
  - Required: writes @0xFFFF then @0x0000.
- Stalls:
  - Stimulus: `in_valid` toggled randomly over the basic-load stream.
  - Required: same writes as the basic load; `in_ready`=0 during WRITE and ADV; no byte lost or duplicated.
- Verify (`LC3_LOADER_VERIFY_EN`):
  - Stimulus: force `mem_q`=0x0000 in VCMP for word 0x1234.
  - Required: `error`=1, `done`=0, `busy`=0, no further writes.
  - Then `start`: `error` clears and the load restarts.
- Reset mid-load:
  - Stimulus: assert `reset` after the first word's WRITE.
  - Required: all outputs 0 in the same cycle; the next `start` loads cleanly, with the assembler phase reset.

Source files
------------

// File: rtl/lc3_loader_pkg.sv
// Shared types for the LC-3 object-image loader.
// State encoding and object-format framing constants.
package lc3_loader_pkg;

  localparam int HDR_WORDS      = 2;
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [3:0] {
    IDLE,
    ORG,
    CNT,
    DATA,
    WRITE,
    VRD,
    VCMP,
    ADV,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/byte_pair_assembler.sv
// Packs a big-endian byte stream into 16-bit words.
// Emits a one-cycle word pulse on the second byte of each pair.
module byte_pair_assembler
  import lc3_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clear,
  input  logic                        i_fire,
  input  logic [7:0]                  i_byte,
  output logic                        o_word_valid,
  output logic [BYTES_PER_WORD*8-1:0] o_word
);

  logic       r_phase;
  logic [7:0] r_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_hi    <= 8'h00;
    end else if (i_clear) begin
      r_phase <= 1'b0;
    end else if (i_fire) begin
      r_phase <= ~r_phase;
      if (!r_phase)
        r_hi <= i_byte;
    end
  end

  assign o_word_valid = i_fire & r_phase;
  assign o_word       = {r_hi, i_byte};

endmodule

// File: rtl/lc3_obj_loader.sv
// LC-3 object-format loader driving the RAM direct port.
// Define LC3_LOADER_VERIFY_EN to read back and compare every write.
module lc3_obj_loader
  import lc3_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] data_out,
  output logic              wren_out,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_written
);

  state_t            r_state;
  state_t            w_next;
  logic              r_run;
  logic [ADDR_W-1:0] r_org;
  logic [ADDR_W-1:0] r_ptr;
  logic [15:0]       r_remaining;
  logic [DATA_W-1:0] r_word;
  logic [15:0]       r_ww;
  logic              w_go;
  logic              w_fire;
  logic              w_wv;
  logic [15:0]       w_word;
  logic              w_rest;

  // Release is retimed so the first transition lands one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  assign w_rest = (r_state == IDLE) ||
                  (r_state == DONE) ||
                  (r_state == ERROR);
  assign w_go   = start & r_run & w_rest;
  assign w_fire = in_valid & in_ready;

  byte_pair_assembler u_asm (
    .clk          (clk),
    .rst_n        (reset),
    .i_clear      (w_go),
    .i_fire       (w_fire),
    .i_byte       (in_data),
    .o_word_valid (w_wv),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE, ERROR:
        if (w_go) w_next = ORG;
      ORG:
        if (w_wv) w_next = CNT;
      CNT:
        if (w_wv)
          w_next = (w_word == 16'h0) ? DONE : DATA;
      DATA:
        if (w_wv) w_next = WRITE;
`ifdef LC3_LOADER_VERIFY_EN
      WRITE:
        w_next = VRD;
      VRD:
        w_next = VCMP;
      VCMP:
        w_next = (mem_q != r_word) ? ERROR : ADV;
`else
      WRITE:
        w_next = ADV;
`endif
      ADV:
        w_next = (r_remaining == 16'd1) ? DONE : DATA;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_org       <= '0;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_ww        <= '0;
    end else begin
      if (w_go)
        r_ww <= '0;
      if (r_state == ORG && w_wv)
        r_org <= w_word[ADDR_W-1:0];
      if (r_state == CNT && w_wv) begin
        r_remaining <= w_word;
        r_ptr       <= r_org;
      end
      if (r_state == DATA && w_wv)
        r_word <= w_word[DATA_W-1:0];
      if (r_state == ADV) begin
        r_ptr       <= r_ptr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
        r_ww        <= r_ww + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = 1'b0;
    wren_out = 1'b0;
    busy     = ~w_rest;
    done     = 1'b0;
    error    = 1'b0;
    unique case (1'b1)
      (r_state == ORG),
      (r_state == CNT),
      (r_state == DATA):  in_ready = 1'b1;
      (r_state == WRITE): wren_out = 1'b1;
      (r_state == DONE):  done     = 1'b1;
`ifdef LC3_LOADER_VERIFY_EN
      (r_state == ERROR): error    = 1'b1;
`endif
      default: ;
    endcase
  end

`ifndef LC3_LOADER_VERIFY_EN
  logic w_unused;
  assign w_unused = ^{mem_q, 1'b0};
`endif

  assign address_out   = r_ptr;
  assign data_out      = r_word;
  assign words_written = r_ww;

endmodule

// File: tb/tb_lc3_obj_loader.sv
// Scoreboard bench for lc3_obj_loader.
// Expected writes are queued by stimulus and popped by a monitor.
module tb_lc3_obj_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] address_out;
  logic [15:0] data_out;
  logic        wren_out;
  logic [15:0] mem_q;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  lc3_obj_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .address_out   (address_out),
    .data_out      (data_out),
    .wren_out      (wren_out),
    .mem_q         (mem_q),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  logic [15:0] mem [0:65535];
  logic [15:0] mem_q_r;
  bit          corrupt = 1'b0;

  always @(posedge clk) begin
    if (wren_out) mem[address_out] <= data_out;
    mem_q_r <= mem[address_out];
  end

  assign mem_q = corrupt ? 16'h0000 : mem_q_r;

  int          checks = 0;
  int          passes = 0;
  int          wren_cnt = 0;
  bit          prev_wren = 1'b0;
  logic [31:0] expq[$];

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (reset && wren_out) begin
      wren_cnt++;
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got %h @%h",
                 data_out, address_out);
      end else begin
        chk("write", {address_out, data_out}, expq.pop_front());
      end
      chk("in_ready_in_write", in_ready, 0);
    end
    if (reset && prev_wren)
      chk("in_ready_after_write", in_ready, 0);
    prev_wren = reset && wren_out;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit stall);
    int n;
    bit acc;
    n = 0;
    do begin
      @(negedge clk);
      in_data  = b;
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = in_valid && in_ready;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: byte %h got no accept want accept", b);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit stall);
    send(w[15:8], stall);
    send(w[7:0], stall);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) begin
      checks++;
      $display("FAIL end_timeout: got no done/error want one");
    end
  endtask

  task automatic load(input logic [15:0] org, input logic [15:0] cnt,
                      input logic [15:0] w0, input logic [15:0] w1,
                      input bit stall);
    wren_cnt = 0;
    pulse_start();
    send_word(org, stall);
    send_word(cnt, stall);
    if (cnt > 0) begin
      expq.push_back({org, w0});
      send_word(w0, stall);
    end
    if (cnt > 1) begin
      expq.push_back({org + 16'd1, w1});
      send_word(w1, stall);
    end
    idle_in();
    wait_end();
    chk("done", done, 1);
    chk("error", error, 0);
    chk("busy", busy, 0);
    chk("words_written", words_written, cnt);
    chk("wren_pulses", wren_cnt, cnt);
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1 reset = 1'b0;
    #1;
    chk("reset_outputs",
        {in_ready, wren_out, busy, done, error,
         address_out, data_out, words_written}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    load(16'h3000, 16'd2, 16'h1234, 16'hABCD, 1'b0);
    load(16'h4000, 16'd0, 16'h0000, 16'h0000, 1'b0);
    load(16'hFFFF, 16'd2, 16'h1111, 16'h2222, 1'b0);
    load(16'h3000, 16'd2, 16'h1234, 16'hABCD, 1'b1);

    // Abort right after the first word is written.
    wren_cnt = 0;
    pulse_start();
    send_word(16'h3000, 1'b0);
    send_word(16'h0002, 1'b0);
    expq.push_back({16'h3000, 16'h1234});
    send_word(16'h1234, 1'b0);
    idle_in();
    for (int n = 0; n < 50 && wren_cnt == 0; n++)
      @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("reset_midload",
        {in_ready, wren_out, busy, done, error,
         address_out, data_out, words_written}, 0);
    chk("midload_writes", wren_cnt, 1);
    chk("midload_queue", expq.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    load(16'h5000, 16'd2, 16'hBEEF, 16'h0001, 1'b0);

    // Reset with the assembler holding a lone high byte.
    pulse_start();
    send(8'h60, 1'b0);
    idle_in();
    reset = 1'b0;
    #1;
    chk("reset_after_odd_byte", {busy, in_ready}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    load(16'h7000, 16'd1, 16'h5A5A, 16'h0000, 1'b0);

`ifdef LC3_LOADER_VERIFY_EN
    corrupt  = 1'b1;
    wren_cnt = 0;
    pulse_start();
    send_word(16'h3000, 1'b0);
    send_word(16'h0002, 1'b0);
    expq.push_back({16'h3000, 16'h1234});
    send_word(16'h1234, 1'b0);
    idle_in();
    wait_end();
    chk("verify_error", error, 1);
    chk("verify_done", done, 0);
    chk("verify_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("verify_no_more_writes", wren_cnt, 1);
    corrupt = 1'b0;
    load(16'h3000, 16'd2, 16'h1234, 16'hABCD, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
